move_checker_knight: RTL and testbench
======================================

Name: move_checker_knight

Overview:
- Registered legality checker for a single knight move in the chess engine's move-generation and validation path.
- Takes an encoded source piece and an encoded destination square/occupant.
- Outputs a valid flag and a 16-bit formatted move word one clock later.
- Purely positional check: no board scan is needed, because knights jump.

Parameters:
- None. Field widths are fixed by the shared piece and move formats.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- src_piece  input  10  moving piece, {type[9:7], col[6:4], row[3:1], color[0]}.
- dest_piece  input  10  destination occupant, same format; type EMPTY means an empty square (its color bit is ignored).
- valid  output  1  registered: the move is a legal knight move.
- formatted_move  output  16  registered: {2'b00, promo[13], capture[12], src_col[11:9], src_row[8:6], dest_col[5:3], dest_row[2:0]}.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: valid=0 and formatted_move=16'h0000, applied immediately on rst assertion. The same values are held for every cycle rst is high.
- Latency: inputs are sampled every rising clk edge and results appear after that edge (1 cycle). There is no handshake; every cycle is evaluated.
- Geometry:
  - dc = dest_col - src_col and dr = dest_row - src_row, computed as 4-bit signed values (zero-extend both operands first).
  - A geometric match requires (|dc|,|dr|) to be (1,2) or (2,1).
  - 3-bit wrap-around never yields a match; for example, col 0 to col 7 gives |dc|=7.
- Occupancy:
  - Legal if dest type == EMPTY.
  - Legal if dest color != src color (a capture).
  - A same-colour occupied destination is illegal.
  - src == dest is illegal because it fails the geometry check.
- Source: if src type == EMPTY, valid=0.
- valid = geometry AND occupancy AND source-type rule.
- formatted_move:
  - When valid=1: promo=0 (a knight never promotes); capture=1 iff dest type != EMPTY; coordinate fields copied from the inputs; bits[15:14]=0.
  - When valid=0: formatted_move=16'h0000.
- Colour rules are symmetric: WHITE and BLACK behave identically.

Optional Feature:
- Macro MCK_SRC_TYPE_CHECK_EN.
- Defined: valid additionally requires src type == KNIGHT; any other source type gives valid=0 and move 0.
- Undefined: src type is ignored except for EMPTY, which still gives valid=0.

Decomposition:
- Shared package zezima_pkg (used codebase-wide) holds:
  - Piece types: EMPTY=0, PAWN=1, KNIGHT=2, BISHOP=3, ROOK=4, QUEEN=5, KING=6.
  - Colours: WHITE=0, BLACK=1.
  - Files: A..H = 0..7.
  - Ranks: ONE..EIGHT = 0..7.
  - Piece and move field offsets, and the PROMO bit index (13) and CAPTURE bit index (12).
- Optional sub-module knight_delta_check: combinational; takes the two coordinate pairs and outputs the geometric match.
- Top level adds the occupancy logic, move formatting and output registers.

Test Plan:
- Quiet move: white knight c3 (src 10'b010_010_010_0) to empty d5 (col3,row4), clock once -> valid=1, formatted_move=16'h049C.
- Capture: same source, dest {KNIGHT,3,4,BLACK} -> valid=1, formatted_move=16'h149C. Repeat with colours swapped -> same result.
- Full sweep: files C–F × ranks 3–6 for both colours, all 8 L-offsets, each as an empty destination and as an opposite-colour capture -> valid=1 in all 256 cases; promo bit always 0.
- Illegal moves, each -> valid=0 and formatted_move=0:
  - Friendly occupant at an L-target.
  - c3 to e5 (diagonal).
  - c3 to c3 (same square).
  - a3 to (7,4), the wrap case of file-1.
- Reset: assert rst mid-stream while valid=1 -> valid=0 and move=0 without waiting for a clock edge. Deassert -> results resume one edge later.
- With MCK_SRC_TYPE_CHECK_EN: src type BISHOP, geometrically legal L move -> valid=0. Without the macro the same stimulus -> valid=1.

Source files
------------

// File: rtl/zezima_pkg.sv
// Shared chess encodings: piece types, colours, files/ranks, and the bit
// layout of the 10-bit piece word and the 16-bit move word.
package zezima_pkg;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_type_e;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } color_e;

  typedef enum logic [2:0] {
    FILE_A, FILE_B, FILE_C, FILE_D, FILE_E, FILE_F, FILE_G, FILE_H
  } file_e;

  typedef enum logic [2:0] {
    RANK_ONE, RANK_TWO, RANK_THREE, RANK_FOUR,
    RANK_FIVE, RANK_SIX, RANK_SEVEN, RANK_EIGHT
  } rank_e;

  // Piece word: {type[9:7], col[6:4], row[3:1], color[0]}
  localparam int PIECE_TYPE_LSB  = 7;
  localparam int PIECE_COL_LSB   = 4;
  localparam int PIECE_ROW_LSB   = 1;
  localparam int PIECE_COLOR_BIT = 0;

  // Move word: {2'b00, promo, capture, src_col, src_row, dest_col, dest_row}
  localparam int MOVE_PROMO_BIT    = 13;
  localparam int MOVE_CAPTURE_BIT  = 12;
  localparam int MOVE_SRC_COL_LSB  = 9;
  localparam int MOVE_SRC_ROW_LSB  = 6;
  localparam int MOVE_DEST_COL_LSB = 3;
  localparam int MOVE_DEST_ROW_LSB = 0;

endpackage

// File: rtl/knight_delta_check.sv
// Combinational knight geometry test: true when the square offset is an L
// shape, i.e. (|dc|,|dr|) is (1,2) or (2,1).
module knight_delta_check (
  input  logic [2:0] src_col,
  input  logic [2:0] src_row,
  input  logic [2:0] dest_col,
  input  logic [2:0] dest_row,
  output logic       match
);

  logic signed [3:0] dc;
  logic signed [3:0] dr;
  logic [3:0]        abs_dc;
  logic [3:0]        abs_dr;

  // Zero-extending to 4 bits keeps 0->7 as a distance of 7 rather than -1.
  assign dc = $signed({1'b0, dest_col}) - $signed({1'b0, src_col});
  assign dr = $signed({1'b0, dest_row}) - $signed({1'b0, src_row});

  assign abs_dc = dc[3] ? -dc : dc;
  assign abs_dr = dr[3] ? -dr : dr;

  assign match = ((abs_dc == 4'd1) && (abs_dr == 4'd2)) ||
                 ((abs_dc == 4'd2) && (abs_dr == 4'd1));

endmodule

// File: rtl/move_checker_knight.sv
// Registered knight-move legality checker and move formatter.
// Define MCK_SRC_TYPE_CHECK_EN to also require the source piece to be a KNIGHT.
module move_checker_knight
  import zezima_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  src_piece,
  input  logic [9:0]  dest_piece,
  output logic        valid,
  output logic [15:0] formatted_move
);

  logic [2:0] src_type, src_col, src_row;
  logic [2:0] dest_type, dest_col, dest_row;
  logic       src_color, dest_color;

  assign src_type   = src_piece[PIECE_TYPE_LSB +: 3];
  assign src_col    = src_piece[PIECE_COL_LSB +: 3];
  assign src_row    = src_piece[PIECE_ROW_LSB +: 3];
  assign src_color  = src_piece[PIECE_COLOR_BIT];
  assign dest_type  = dest_piece[PIECE_TYPE_LSB +: 3];
  assign dest_col   = dest_piece[PIECE_COL_LSB +: 3];
  assign dest_row   = dest_piece[PIECE_ROW_LSB +: 3];
  assign dest_color = dest_piece[PIECE_COLOR_BIT];

  logic geom_ok;

  knight_delta_check u_delta (
    .src_col  (src_col),
    .src_row  (src_row),
    .dest_col (dest_col),
    .dest_row (dest_row),
    .match    (geom_ok)
  );

  logic        dest_empty;
  logic        occ_ok;
  logic        src_ok;
  logic        valid_d;
  logic [15:0] move_d;

  assign dest_empty = (dest_type == EMPTY);
  assign occ_ok     = dest_empty || (dest_color != src_color);

`ifdef MCK_SRC_TYPE_CHECK_EN
  assign src_ok = (src_type == KNIGHT);
`else
  assign src_ok = (src_type != EMPTY);
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d = 1'b0;
    move_d  = '0;
    if (geom_ok && occ_ok && src_ok) begin
      valid_d                             = 1'b1;
      move_d[MOVE_PROMO_BIT]              = 1'b0;
      move_d[MOVE_CAPTURE_BIT]            = !dest_empty;
      move_d[MOVE_SRC_COL_LSB +: 3]       = src_col;
      move_d[MOVE_SRC_ROW_LSB +: 3]       = src_row;
      move_d[MOVE_DEST_COL_LSB +: 3]      = dest_col;
      move_d[MOVE_DEST_ROW_LSB +: 3]      = dest_row;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid          <= 1'b0;
      formatted_move <= '0;
    end else begin
      valid          <= valid_d;
      formatted_move <= move_d;
    end
  end

endmodule

// File: tb/tb_move_checker_knight.sv
// Self-checking bench for move_checker_knight: directed cases, a full legal
// sweep, reset behaviour, and randomized stimulus against a reference model.
module tb_move_checker_knight;

  logic        clk;
  logic        rst;
  logic [9:0]  src_piece;
  logic [9:0]  dest_piece;
  logic        valid;
  logic [15:0] formatted_move;

  int n_checks = 0;
  int n_pass   = 0;

  move_checker_knight dut (
    .clk            (clk),
    .rst            (rst),
    .src_piece      (src_piece),
    .dest_piece     (dest_piece),
    .valid          (valid),
    .formatted_move (formatted_move)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [9:0] pc(input int t, input int c, input int r, input int color);
    return 10'(t * 128 + c * 16 + r * 2 + color);
  endfunction

  // Reference model from the chess rules, returns {valid, move}.
  function automatic logic [16:0] model(input logic [9:0] s, input logic [9:0] d);
    int st, sc, sr, scolor, dt, dcol, drow, dcolor, ddc, ddr, mv;
    bit ok;
    st = int'(s) / 128; sc = (int'(s) / 16) % 8; sr = (int'(s) / 2) % 8; scolor = int'(s) % 2;
    dt = int'(d) / 128; dcol = (int'(d) / 16) % 8; drow = (int'(d) / 2) % 8; dcolor = int'(d) % 2;
    ddc = dcol - sc; if (ddc < 0) ddc = -ddc;
    ddr = drow - sr; if (ddr < 0) ddr = -ddr;
    ok = (ddc * ddr == 2);
    if (dt != 0 && dcolor == scolor) ok = 0;
`ifdef MCK_SRC_TYPE_CHECK_EN
    if (st != 2) ok = 0;
`else
    if (st == 0) ok = 0;
`endif
    if (!ok) return 17'd0;
    mv = ((dt != 0) ? 4096 : 0) + sc * 512 + sr * 64 + dcol * 8 + drow;
    return {1'b1, 16'(mv)};
  endfunction

  task automatic drive_and_sample(input logic [9:0] s, input logic [9:0] d);
    @(negedge clk);
    src_piece  = s;
    dest_piece = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_exp(input string tag, input logic [9:0] s, input logic [9:0] d,
                         input logic ev, input logic [15:0] em);
    drive_and_sample(s, d);
    check({tag, ".valid"}, 32'(valid), 32'(ev));
    check({tag, ".move"}, 32'(formatted_move), 32'(em));
  endtask

  task automatic run_model(input string tag, input logic [9:0] s, input logic [9:0] d);
    logic [16:0] e;
    e = model(s, d);
    run_exp(tag, s, d, e[16], e[15:0]);
  endtask

  int dcs[8] = '{1, 2, 2, 1, -1, -2, -2, -1};
  int drs[8] = '{2, 1, -1, -2, -2, -1, 1, 2};

  initial begin
    logic [9:0] c3_w;
    logic       exp_bishop;
    rst        = 1'b1;
    src_piece  = '0;
    dest_piece = '0;
    #1;
    check("reset.valid", 32'(valid), 32'd0);
    check("reset.move", 32'(formatted_move), 32'd0);
    @(posedge clk);
    #1;
    check("reset_hold.valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    c3_w = pc(2, 2, 2, 0);
    run_exp("quiet_c3d5", c3_w, pc(0, 3, 4, 1), 1'b1, 16'h049C);
    run_exp("capture_w", c3_w, pc(2, 3, 4, 1), 1'b1, 16'h149C);
    run_exp("capture_b", pc(2, 2, 2, 1), pc(2, 3, 4, 0), 1'b1, 16'h149C);

    run_exp("friendly", c3_w, pc(4, 3, 4, 0), 1'b0, 16'h0000);
    run_exp("diagonal", c3_w, pc(0, 4, 4, 0), 1'b0, 16'h0000);
    run_exp("same_sq", c3_w, c3_w, 1'b0, 16'h0000);
    run_exp("wrap_a3", pc(2, 0, 2, 0), pc(0, 7, 4, 0), 1'b0, 16'h0000);
    run_exp("src_empty", pc(0, 2, 2, 0), pc(0, 3, 4, 0), 1'b0, 16'h0000);

`ifdef MCK_SRC_TYPE_CHECK_EN
    exp_bishop = 1'b0;
`else
    exp_bishop = 1'b1;
`endif
    run_exp("bishop_src", pc(3, 2, 2, 0), pc(0, 3, 4, 0), exp_bishop,
            exp_bishop ? 16'h049C : 16'h0000);

    // Full legal sweep over central squares.
    for (int c = 2; c <= 5; c++)
      for (int r = 2; r <= 5; r++)
        for (int color = 0; color < 2; color++)
          for (int k = 0; k < 8; k++)
            for (int cap = 0; cap < 2; cap++) begin
              int dt;
              dt = cap ? int'($urandom_range(1, 6)) : 0;
              run_model("sweep", pc(2, c, r, color), pc(dt, c + dcs[k], r + drs[k], 1 - color));
              check("sweep.valid1", 32'(valid), 32'd1);
              check("sweep.promo", 32'(formatted_move[13]), 32'd0);
            end

    // Asynchronous reset while a valid result is held.
    run_exp("pre_reset", c3_w, pc(0, 3, 4, 0), 1'b1, 16'h049C);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.valid", 32'(valid), 32'd0);
    check("async_rst.move", 32'(formatted_move), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held.valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_released_noedge.valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    check("resume.valid", 32'(valid), 32'd1);
    check("resume.move", 32'(formatted_move), 32'h049C);

    // Randomized stimulus, half biased toward L-shaped targets.
    for (int i = 0; i < 1500; i++) begin
      int st, sc, sr, scol, dt, dc, dr, dcol;
      st = int'($urandom_range(0, 7)); sc = int'($urandom_range(0, 7));
      sr = int'($urandom_range(0, 7)); scol = int'($urandom_range(0, 1));
      dt = int'($urandom_range(0, 7)); dcol = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        int k;
        k  = int'($urandom_range(0, 7));
        dc = (sc + dcs[k]) & 7;
        dr = (sr + drs[k]) & 7;
      end else begin
        dc = int'($urandom_range(0, 7));
        dr = int'($urandom_range(0, 7));
      end
      run_model("random", pc(st, sc, sr, scol), pc(dt, dc, dr, dcol));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
